// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier: unpack/multiply, normalise, round/pack.
// Define FMUL_FLAGS_EN to add the out_flags port {invalid, overflow, underflow, inexact}.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_p
`ifdef FMUL_FLAGS_EN
    ,
    output logic [3:0]           out_flags
`endif
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * (MAN_W + 1);
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic c_nan, c_inf, c_zero;
    logic [EW-1:0] esum;
    logic [PW-1:0] prod;

    assign ea = in_a[W-2:MAN_W];
    assign eb = in_b[W-2:MAN_W];
    assign fa = in_a[MAN_W-1:0];
    assign fb = in_b[MAN_W-1:0];

    // exp==0 covers both true zero and flushed subnormals
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (|fa);
    assign b_nan  = (&eb) && (|fb);

    assign c_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    assign c_inf  = (a_inf | b_inf) & !c_nan;
    assign c_zero = (a_zero | b_zero) & !c_nan;
    assign esum   = EW'(ea) + EW'(eb) - BIAS;
    assign prod   = PW'({1'b1, fa}) * PW'({1'b1, fb});

    logic          s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
    logic [EW-1:0] s1_exp;
    logic [PW-1:0] s1_prod;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_nan   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_exp   <= '0;
            s1_prod  <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sign  <= in_a[W-1] ^ in_b[W-1];
            s1_nan   <= c_nan;
            s1_inf   <= c_inf;
            s1_zero  <= c_zero;
            s1_exp   <= esum;
            s1_prod  <= prod;
        end
    end

    // product in [1,4): a set MSB means one extra right shift
    logic             hi;
    logic [MAN_W-1:0] n_frac;
    logic             n_guard, n_round, n_sticky;
    logic [EW-1:0]    n_exp;

    assign hi       = s1_prod[PW-1];
    assign n_frac   = hi ? s1_prod[PW-2:MAN_W+1] : s1_prod[PW-3:MAN_W];
    assign n_guard  = hi ? s1_prod[MAN_W]        : s1_prod[MAN_W-1];
    assign n_round  = hi ? s1_prod[MAN_W-1]      : s1_prod[MAN_W-2];
    assign n_sticky = hi ? |s1_prod[MAN_W-2:0]   : |s1_prod[MAN_W-3:0];
    assign n_exp    = s1_exp + EW'(hi);

    logic             s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
    logic [EW-1:0]    s2_exp;
    logic [MAN_W-1:0] s2_frac;
    logic             s2_guard, s2_round, s2_sticky;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_nan    <= 1'b0;
            s2_inf    <= 1'b0;
            s2_zero   <= 1'b0;
            s2_exp    <= '0;
            s2_frac   <= '0;
            s2_guard  <= 1'b0;
            s2_round  <= 1'b0;
            s2_sticky <= 1'b0;
        end else if (advance) begin
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_nan    <= s1_nan;
            s2_inf    <= s1_inf;
            s2_zero   <= s1_zero;
            s2_exp    <= n_exp;
            s2_frac   <= n_frac;
            s2_guard  <= n_guard;
            s2_round  <= n_round;
            s2_sticky <= n_sticky;
        end
    end

    logic             rnd_up, carry, ovf, unf, lost;
    logic [MAN_W-1:0] r_frac;
    logic [EW-1:0]    r_exp;
    logic [W-1:0]     res;

    assign rnd_up          = s2_guard & (s2_round | s2_sticky | s2_frac[0]);
    assign {carry, r_frac} = {1'b0, s2_frac} + (MAN_W + 1)'(rnd_up);
    assign r_exp           = s2_exp + EW'(carry);
    assign ovf             = !r_exp[EW-1] && (r_exp >= EMAX);
    assign unf             = r_exp[EW-1] || (r_exp == '0);
    assign lost            = s2_guard | s2_round | s2_sticky;

    always_comb begin
        res = {s2_sign, r_exp[EXP_W-1:0], r_frac};
        if (s2_nan)
            res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        else if (s2_inf || (!s2_zero && ovf))
            res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (s2_zero || unf)
            res = {s2_sign, {(W-1){1'b0}}};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_p     <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            out_p     <= res;
        end
    end

`ifdef FMUL_FLAGS_EN
    logic c_flush, s1_flush, s2_flush, normal;
    logic [3:0] flags;

    assign c_flush = ((ea == '0) && (|fa)) || ((eb == '0) && (|fb));
    assign normal  = !s2_nan && !s2_inf && !s2_zero;

    // a flushed subnormal only matters when the result is a plain zero
    always_comb begin
        flags    = '0;
        flags[3] = s2_nan;
        flags[2] = normal & ovf;
        flags[1] = (normal & unf) | (s2_zero & s2_flush);
        flags[0] = (normal & (lost | ovf | unf)) | (s2_zero & s2_flush);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_flush  <= 1'b0;
            s2_flush  <= 1'b0;
            out_flags <= '0;
        end else if (advance) begin
            s1_flush  <= c_flush;
            s2_flush  <= s1_flush;
            out_flags <= flags;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed vectors, randomised stream against an
// integer-arithmetic reference, backpressure and mid-flight reset.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_p;
`ifdef FMUL_FLAGS_EN
    logic [3:0]  out_flags;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk),
        .rstn(rstn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p(out_p)
`ifdef FMUL_FLAGS_EN
        ,
        .out_flags(out_flags)
`endif
    );

    // reference: returns {invalid, overflow, underflow, inexact, product}
    function automatic logic [35:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        longint unsigned m, q, rem, half;
        bit an, bn, ai, bi, az, bz, sub;
        s   = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        an  = (ea == 255) && (a[22:0] != 0);
        bn  = (eb == 255) && (b[22:0] != 0);
        ai  = (ea == 255) && (a[22:0] == 0);
        bi  = (eb == 255) && (b[22:0] == 0);
        az  = (ea == 0);
        bz  = (eb == 0);
        sub = (az && a[22:0] != 0) || (bz && b[22:0] != 0);
        if (an || bn || (ai && bz) || (bi && az))
            return {4'b1000, 32'h7FC00000};
        if (ai || bi)
            return {4'b0000, s, 8'hFF, 23'd0};
        if (az || bz)
            return {(sub ? 4'b0011 : 4'b0000), s, 31'd0};
        m    = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        e    = ea + eb - 127;
        sh   = (m >= (64'd1 << 47)) ? 24 : 23;
        if (sh == 24) e++;
        q    = m >> sh;
        rem  = m & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0011, s, 31'd0};
        return {3'b000, (rem != 0), s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 19))
            0: v[30:0] = '0;
            1: v[30:0] = {8'hFF, 23'd0};
            2: v[30:23] = 8'hFF;
            3: v[30:23] = 8'h00;
            4: v[30:23] = 8'($urandom_range(1, 70));
            5: v[30:23] = 8'($urandom_range(190, 254));
            6: v[22:0] = 23'h7FFFFF;
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_p !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: out_valid=%b out_p=%h want 0/0",
                     out_valid, out_p);
        end
`ifdef FMUL_FLAGS_EN
        n_cmp++;
        if (out_flags !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000", out_flags);
        end
`endif
        rstn = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [10] = '{32'h3FC00000, 32'h3F800001, 32'hBF800000,
                                 32'h7F800000, 32'h7F7FFFFF, 32'h80800000,
                                 32'h00000001, 32'hFF800000, 32'h80000000,
                                 32'h7F800001};
        logic [31:0] vb [10] = '{32'h40000000, 32'h3F800001, 32'h3F800000,
                                 32'h00000000, 32'h40000000, 32'h3F000000,
                                 32'h3F800000, 32'h40000000, 32'h3F800000,
                                 32'h3F800000};
        logic [31:0] vp [10] = '{32'h40400000, 32'h3F800002, 32'hBF800000,
                                 32'h7FC00000, 32'h7F800000, 32'h80000000,
                                 32'h00000000, 32'hFF800000, 32'h80000000,
                                 32'h7FC00000};
        logic [3:0]  vf [10] = '{4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0101,
                                 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b1000};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = va[i];
            in_b = vb[i];
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL latency_early[%0d]: out_valid=%b want 0",
                         i, out_valid);
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_p !== vp[i]) begin
                n_bad++;
                $display("FAIL directed[%0d]: valid=%b p=%h want 1/%h",
                         i, out_valid, out_p, vp[i]);
            end
`ifdef FMUL_FLAGS_EN
            n_cmp++;
            if (out_flags !== vf[i]) begin
                n_bad++;
                $display("FAIL directed_flags[%0d]: got %b want %b",
                         i, out_flags, vf[i]);
            end
`else
            if (vf[i] === 4'bxxxx) $display("unused %0d", i);
`endif
        end
    endtask

    task automatic test_random();
        logic [35:0] q[$];
        logic [35:0] exp_v;
        int sent = 0;
        int cyc = 0;
        while ((sent < 300 || q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 300) && ($urandom_range(0, 4) != 0);
            in_a = rnd_op();
            in_b = rnd_op();
            #1;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL random_extra: unexpected p=%h", out_p);
                end else begin
                    exp_v = q.pop_front();
                    if (out_p !== exp_v[31:0]) begin
                        n_bad++;
                        $display("FAIL random_p: got %h want %h",
                                 out_p, exp_v[31:0]);
                    end
`ifdef FMUL_FLAGS_EN
                    else if (out_flags !== exp_v[35:32]) begin
                        n_bad++;
                        $display("FAIL random_flags: p=%h got %b want %b",
                                 out_p, out_flags, exp_v[35:32]);
                    end
`endif
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_mul(in_a, in_b));
                sent++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (q.size() != 0 || sent != 300) begin
            n_bad++;
            $display("FAIL random_drain: sent=%0d left=%0d want 300/0",
                     sent, q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] q[$];
        logic [35:0] exp_v;
        logic [31:0] prev_p = '0;
        logic        hold = 1'b0;
        int sent = 0;
        int got = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 7);
            in_valid  = (sent < 8);
            in_a = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
            in_b = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
            #1;
            if (c == 4) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_in_ready: got %b want 0", in_ready);
                end
            end
            if (hold) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_p !== prev_p) begin
                    n_bad++;
                    $display("FAIL b2b_hold: valid=%b p=%h want 1/%h",
                             out_valid, out_p, prev_p);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                got++;
                exp_v = (q.size() != 0) ? q.pop_front() : 36'hF_FFFF_FFFF;
                if (out_p !== exp_v[31:0]) begin
                    n_bad++;
                    $display("FAIL b2b_order[%0d]: got %h want %h",
                             got, out_p, exp_v[31:0]);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_mul(in_a, in_b));
                sent++;
            end
            hold   = out_valid && !out_ready;
            prev_p = out_p;
            if (got == 8 && sent == 8) break;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (got != 8 || sent != 8 || q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_count: got=%0d sent=%0d want 8/8", got, sent);
        end
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 32'h3FC00000;
        in_b = 32'h40000000;
        @(negedge clk);
        in_a = 32'h40000000;
        in_b = 32'h40400000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL inflight_pre: out_valid=%b want 1", out_valid);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_p !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: valid=%b p=%h want 0/0",
                     out_valid, out_p);
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL stale_result[%0d]: valid=%b p=%h want 0",
                         i, out_valid, out_p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

endmodule
